// File: rtl/oram_path_ctrl.sv
// Path-ORAM access sequencer: owns the position map, stash and remap LFSR, and walks one
// root->leaf path read then leaf->root path write-back per host request.
module oram_path_ctrl #(
  parameter int unsigned D     = 6,
  parameter int unsigned K     = 3,
  parameter int unsigned A     = 8,
  parameter int unsigned STASH = 16,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int unsigned TW   = 1 + (D - 1) + D + 8 * A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [D-1:0]      req_bnum,
  input  logic [8*A-1:0]    req_wdata,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [8*A-1:0]    rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [D-1:0]      mem_addr,
  output logic [K*TW-1:0]   mem_wdata,
  input  logic [K*TW-1:0]   mem_rdata,
  output logic              busy,
  output logic              stash_overflow
);
  localparam int unsigned DW = 8 * A;
  localparam int unsigned LW = D - 1;
  localparam int unsigned CW = $clog2(D + 1);
  localparam logic [CW-1:0] LastRd = CW'(D);
  localparam logic [CW-1:0] LastWr = CW'(D - 1);

  typedef enum logic [2:0] {StIdle, StPosmap, StRead, StServe, StWrite, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q;
  logic [LW-1:0] new_leaf, old_leaf_q, new_leaf_q;
  logic          req_write_q;
  logic [D-1:0]  req_bnum_q;
  logic [DW-1:0] req_wdata_q;
  logic [LW:0]   pm_q [2**D];
  logic [TW-1:0] stash_q [STASH];
  logic [TW-1:0] stash_d [STASH];
  logic          ovf_q, ovf_d;
  logic          rsp_valid_q, rsp_hit_q, rsp_hit_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [TW-1:0] tup;
  logic [LW-1:0] mask;
  logic          found;
  int unsigned   slot, lvl;

  // Node index at depth lvl along the path to leaf; leaf bit l steers level l -> l+1.
  function automatic logic [D-1:0] path_node(input logic [LW-1:0] leaf, input int unsigned lv);
    logic [D-1:0] n;
    n = '0;
    for (int unsigned l = 0; l < LW; l++) begin
      if (l < lv) n = (n << 1) + D'(1) + D'(leaf[l]);
    end
    return n;
  endfunction

  assign new_leaf       = lfsr_q[LW-1:0];
  assign req_ready      = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_hit        = rsp_hit_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign stash_overflow = ovf_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stash_d     = stash_q;
    ovf_d       = ovf_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    tup         = '0;
    mask        = '0;
    found       = 1'b0;
    slot        = 0;
    lvl         = 0;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StPosmap;
      StPosmap: begin
        state_d = StRead;
        cnt_d   = '0;
      end
      StRead: begin
        if (cnt_q != LastRd) begin
          mem_en   = 1'b1;
          mem_addr = path_node(old_leaf_q, int'(cnt_q));
        end
        // Bucket requested last cycle is on mem_rdata now; tuples claim free slots in j order.
        if (cnt_q != '0) begin
          for (int unsigned j = 0; j < K; j++) begin
            tup = mem_rdata[j*TW +: TW];
            if (tup[TW-1]) begin
              found = 1'b0;
              for (int unsigned s = 0; s < STASH; s++) begin
                if (!found && !stash_d[s][TW-1]) begin
                  stash_d[s] = tup;
                  found      = 1'b1;
                end
              end
              if (!found) ovf_d = 1'b1;
            end
          end
        end
        if (cnt_q == LastRd) state_d = StServe;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      StServe: begin
        for (int unsigned s = 0; s < STASH; s++) begin
          if (!found && stash_q[s][TW-1] && stash_q[s][DW +: D] == req_bnum_q) begin
            found                 = 1'b1;
            rsp_rdata_d           = stash_q[s][DW-1:0];
            stash_d[s][TW-2 -: LW] = new_leaf_q;
            if (req_write_q) stash_d[s][DW-1:0] = req_wdata_q;
          end
        end
        rsp_hit_d = found;
        if (!found) begin
          rsp_rdata_d = '0;
          if (req_write_q) begin
            for (int unsigned s = 0; s < STASH; s++) begin
              if (!found && !stash_q[s][TW-1]) begin
                stash_d[s] = {1'b1, new_leaf_q, req_bnum_q, req_wdata_q};
                found      = 1'b1;
              end
            end
            if (!found) ovf_d = 1'b1;
          end
        end
        state_d = StWrite;
        cnt_d   = '0;
      end
      StWrite: begin
        lvl      = LW - int'(cnt_q);
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = path_node(old_leaf_q, lvl);
        for (int unsigned i = 0; i < LW; i++) mask[i] = (i < lvl);
        for (int unsigned s = 0; s < STASH; s++) begin
          if (stash_q[s][TW-1] && slot < K &&
              ((stash_q[s][TW-2 -: LW] ^ old_leaf_q) & mask) == '0) begin
            mem_wdata[slot*TW +: TW] = stash_q[s];
            stash_d[s][TW-1]         = 1'b0;
            slot                     = slot + 1;
          end
        end
        if (cnt_q == LastWr) state_d = StResp;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lfsr_q      <= SEED;
      old_leaf_q  <= '0;
      new_leaf_q  <= '0;
      req_write_q <= 1'b0;
      req_bnum_q  <= '0;
      req_wdata_q <= '0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
      for (int i = 0; i < 2**D; i++) pm_q[i] <= '0;
      for (int i = 0; i < STASH; i++) stash_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      stash_q     <= stash_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= (state_q == StResp);
      rsp_hit_q   <= rsp_hit_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (state_q == StIdle && req_valid) begin
        req_write_q <= req_write;
        req_bnum_q  <= req_bnum;
        req_wdata_q <= req_wdata;
      end
      // The leaf drawn here is kept so SERVE tags the stash entry with the same leaf the map holds.
      if (state_q == StPosmap) begin
        old_leaf_q       <= pm_q[req_bnum_q][LW] ? pm_q[req_bnum_q][LW-1:0] : new_leaf;
        new_leaf_q       <= new_leaf;
        pm_q[req_bnum_q] <= {1'b1, new_leaf};
      end
    end
  end

endmodule
